// File: rtl/axi_lite_multi_adder.sv
// axi_lite_multi_adder
//   AXI4-Lite slave that sums NUM_OPERANDS software-written operands, one
//   operand per clock. Add/sub and accumulate modes, carry/overflow flags,
//   OKAY/SLVERR responses and a level done interrupt.
//
//   Register map (byte address, addr[1:0] ignored):
//     0x00             CTRL    RW  [0] START (self-clearing, reads 0), [1] SUB, [2] ACC
//     0x04             STATUS      [0] BUSY RO, [1] DONE W1C, [2] CARRY RO, [3] OVF RO
//     0x08 + 4*i       OPERAND[i]  RW
//     0x08 + 4*N       RESULT  RO
//     anything else    SLVERR, read data 0
//
//   Ports:
//     s0_axi_aclk / s0_axi_areset   clock, synchronous active-high reset
//     s0_axi_aw* / s0_axi_w* / s0_axi_b*   write address, data, response channels
//     s0_axi_ar* / s0_axi_r*               read address, data channels
//     done_irq                              level interrupt = STATUS.DONE
//
//   Build option: define ADDER_SATURATE_EN to clamp the accumulator to the
//   signed max/min on overflow instead of wrapping (OVF is set either way).
module axi_lite_multi_adder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_OPERANDS = 4
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [1:0]              s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready,
    output logic                    done_irq
);
    localparam int WW = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = $clog2(NUM_OPERANDS + 1);
    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [WW-1:0] W_CTRL   = WW'(0);
    localparam logic [WW-1:0] W_STATUS = WW'(1);
    localparam logic [WW-1:0] W_RESULT = WW'(2 + NUM_OPERANDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef ADDER_SATURATE_EN
    localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, result_q, result_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0] op_q, op_d;
    logic ctrl_sub_q, ctrl_sub_d, ctrl_acc_q, ctrl_acc_d;
    logic done_q, done_d, carry_q, carry_d, ovf_q, ovf_d;
    logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [WW-1:0] aw_word, ar_word;
    logic wr_fire, rd_fire, busy, start, done_clr, wr_err, rd_err;
    logic [DATA_WIDTH-1:0] rd_val, opnd, raw, step_res;
    logic [DATA_WIDTH:0] wide;
    logic step_c, step_v;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};
    assign aw_word = s0_axi_awaddr[ADDR_WIDTH-1:2];
    assign ar_word = s0_axi_araddr[ADDR_WIDTH-1:2];
    assign busy    = (state_q == RUN);

    // Address and data are taken together; a pending response blocks new writes.
    assign wr_fire = s0_axi_awvalid & s0_axi_wvalid & ~bvalid_q & ~s0_axi_areset;
    assign rd_fire = s0_axi_arvalid & ~rvalid_q & ~s0_axi_areset;

    assign s0_axi_awready = wr_fire;
    assign s0_axi_wready  = wr_fire;
    assign s0_axi_arready = rd_fire;
    assign s0_axi_bvalid  = bvalid_q;
    assign s0_axi_bresp   = bresp_q;
    assign s0_axi_rvalid  = rvalid_q;
    assign s0_axi_rresp   = rresp_q;
    assign s0_axi_rdata   = rdata_q;
    assign done_irq       = done_q;

    // Write decode and register updates
    always_comb begin
        op_d       = op_q;
        ctrl_sub_d = ctrl_sub_q;
        ctrl_acc_d = ctrl_acc_q;
        start      = 1'b0;
        done_clr   = 1'b0;
        wr_err     = 1'b0;
        if (wr_fire) begin
            if (aw_word == W_CTRL) begin
                if (busy) begin
                    wr_err = 1'b1;
                end else if (s0_axi_wstrb[0]) begin
                    start      = s0_axi_wdata[0];
                    ctrl_sub_d = s0_axi_wdata[1];
                    ctrl_acc_d = s0_axi_wdata[2];
                end
            end else if (aw_word == W_STATUS) begin
                done_clr = s0_axi_wstrb[0] & s0_axi_wdata[1];
            end else begin
                // RESULT and unmapped addresses stay errors unless an operand matches
                wr_err = 1'b1;
                for (int i = 0; i < NUM_OPERANDS; i++) begin
                    if (aw_word == WW'(2 + i)) begin
                        wr_err = busy;
                        if (!busy) begin
                            for (int b = 0; b < SW; b++) begin
                                if (s0_axi_wstrb[b]) op_d[i][8*b +: 8] = s0_axi_wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end

        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && s0_axi_bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Read path: sampled from current state, so a same-cycle write is not visible
    always_comb begin
        rd_val = '0;
        rd_err = 1'b1;
        if (ar_word == W_CTRL) begin
            rd_val[2:0] = {ctrl_acc_q, ctrl_sub_q, 1'b0};
            rd_err      = 1'b0;
        end else if (ar_word == W_STATUS) begin
            rd_val[3:0] = {ovf_q, carry_q, done_q, busy};
            rd_err      = 1'b0;
        end else if (ar_word == W_RESULT) begin
            rd_val = result_q;
            rd_err = 1'b0;
        end else begin
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (ar_word == WW'(2 + i)) begin
                    rd_val = op_q[i];
                    rd_err = 1'b0;
                end
            end
        end

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && s0_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // One accumulation step; top bit of the widened result is carry (add) or borrow (sub)
    always_comb begin
        opnd = '0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (idx_q == IW'(i)) opnd = op_q[i];
        end
        if (ctrl_sub_q) wide = {1'b0, acc_q} - {1'b0, opnd};
        else            wide = {1'b0, acc_q} + {1'b0, opnd};
        raw    = wide[DATA_WIDTH-1:0];
        step_c = wide[DATA_WIDTH];
        if (ctrl_sub_q) step_v = (acc_q[MSB] != opnd[MSB]) && (raw[MSB] != acc_q[MSB]);
        else            step_v = (acc_q[MSB] == opnd[MSB]) && (raw[MSB] != acc_q[MSB]);
`ifdef ADDER_SATURATE_EN
        // Overflow direction follows the accumulator sign for both add and sub
        step_res = step_v ? (acc_q[MSB] ? SMIN : SMAX) : raw;
`else
        step_res = raw;
`endif
    end

    // Sequencer
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = done_q & ~done_clr;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    done_d  = 1'b0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    acc_d   = ctrl_acc_d ? result_q : op_q[0];
                    idx_d   = ctrl_acc_d ? '0 : IW'(1);
                end
            end
            RUN: begin
                // idx == NUM_OPERANDS is the writeback slot; hardware set beats W1C
                if (idx_q == IW'(NUM_OPERANDS)) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    acc_d   = step_res;
                    carry_d = carry_q | step_c;
                    ovf_d   = ovf_q | step_v;
                    idx_d   = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            op_q       <= '0;
            ctrl_sub_q <= 1'b0;
            ctrl_acc_q <= 1'b0;
            done_q     <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            op_q       <= op_d;
            ctrl_sub_q <= ctrl_sub_d;
            ctrl_acc_q <= ctrl_acc_d;
            done_q     <= done_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule
